// File: rtl/dbus_uncached_responder.sv
// rtl/dbus_uncached_responder.sv - uncached dbus slave with posted write buffer and ordered loads
//
// Purpose:
//   Slave end of the CPU uncached data bus. Stores are posted into a small
//   circular write buffer and complete immediately unless the buffer is full.
//   Loads wait until every earlier store has been issued downstream, then go
//   out as a single-beat read on the memory port.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-low reset
//   dbus_read/write   load/store request from the core, held while dbus_stall=1
//   dbus_address      byte address; dbus_byteenable byte lanes; dbus_wrdata store data
//   dbus_rddata       registered load data, held until the next load returns
//   dbus_stall        combinational; the current request is not complete this cycle
//   mem_req/mem_we    downstream request valid / write(1) or read(0)
//   mem_addr/be/wdata downstream word address, byte enables and write data
//   mem_gnt           downstream accepted the request this cycle
//   mem_rvalid/rdata  read response, one pulse per accepted read

module dbus_uncached_responder #(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     rddata_q, rddata_d;

  // Buffer entries keep only the word address; the byte offset never leaves the block.
  logic [29:0]     wb_addr_q [WB_DEPTH];
  logic [29:0]     wb_addr_d [WB_DEPTH];
  logic [3:0]      wb_be_q   [WB_DEPTH];
  logic [3:0]      wb_be_d   [WB_DEPTH];
  logic [31:0]     wb_data_q [WB_DEPTH];
  logic [31:0]     wb_data_d [WB_DEPTH];

  logic            push;
  logic            pop;
  logic            wr_issue;

  // Byte offset of the dbus address is not needed for word-granular downstream traffic.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^dbus_address[1:0];

  assign dbus_rddata = rddata_q;

  // Write buffer control. A read present in the same cycle always wins, so a
  // malformed read+write request never pushes.
  always_comb begin
    push     = dbus_write && !dbus_read && (state_q == ST_IDLE) && (count_q < FULL);
    wr_issue = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && (count_q != '0);
    pop      = wr_issue && mem_gnt;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // At full no push is possible, so a pop at full simply makes room.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_be_d   = wb_be_q;
    wb_data_d = wb_data_q;
    if (push) begin
      wb_addr_d[wr_ptr_q] = dbus_address[31:2];
      wb_be_d[wr_ptr_q]   = dbus_byteenable;
      wb_data_d[wr_ptr_q] = dbus_wrdata;
    end
  end

  // Downstream mux: buffered writes own the port whenever the buffer is
  // non-empty; the read slot is only reachable once the buffer has drained.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (wr_issue) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {wb_addr_q[rd_ptr_q], 2'b00};
      mem_be    = wb_be_q[rd_ptr_q];
      mem_wdata = wb_data_q[rd_ptr_q];
    end else if (state_q == ST_RD_REQ) begin
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = {dbus_address[31:2], 2'b00};
      mem_be    = dbus_byteenable;
    end
  end

  // Load sequencing and stall generation. Store stall depends only on the
  // registered count so there is no path from mem_gnt to dbus_stall.
  always_comb begin
    state_d    = state_q;
    rddata_d   = rddata_q;
    dbus_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbus_read) begin
          dbus_stall = 1'b1;
          state_d    = (count_q != '0) ? ST_DRAIN : ST_RD_REQ;
        end else if (dbus_write) begin
          dbus_stall = (count_q == FULL);
        end
      end
      ST_DRAIN: begin
        dbus_stall = 1'b1;
        // Post-pop count lets the read go out right after the last write grant.
        if (count_d == '0) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        dbus_stall = 1'b1;
        if (mem_gnt) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        dbus_stall = 1'b1;
        if (mem_rvalid) begin
          rddata_d = mem_rdata;
          state_d  = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        dbus_stall = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rddata_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_be_q[i]   <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rddata_q  <= rddata_d;
      wb_addr_q <= wb_addr_d;
      wb_be_q   <= wb_be_d;
      wb_data_q <= wb_data_d;
    end
  end

  // The core must never present a load and a store together.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(dbus_read && dbus_write))
        else $error("dbus_read and dbus_write asserted together");
    end
  end

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// tb/tb_dbus_uncached_responder.sv - self-checking bench for dbus_uncached_responder
module tb_dbus_uncached_responder;

  localparam int WB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [31:0] dbus_address = '0;
  logic [3:0]  dbus_byteenable = '0;
  logic [31:0] dbus_wrdata = '0;
  logic [31:0] dbus_rddata;
  logic        dbus_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  dbus_uncached_responder #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable),
    .dbus_wrdata(dbus_wrdata), .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  // Downstream responder: writes granted when wr_gnt_en; reads granted on the
  // gnt_delay-th request cycle, data returned rv_delay cycles after the grant.
  bit          wr_gnt_en = 1'b0;
  int          gnt_delay = 1;
  int          rv_delay = 1;
  logic [31:0] rd_data_next = '0;
  int          stray_req = 0;
  int          stray_ack = 0;
  int          rd_cnt = 0;
  int          rv_cnt = 0;
  int          we_cycles = 0;

  always @(posedge clk) begin
    #2;
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data_next;
      end
    end
    if (stray_req != stray_ack) begin
      stray_ack  = stray_req;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    if (mem_req && !mem_we) begin
      rd_cnt++;
      mem_gnt = (rd_cnt >= gnt_delay);
      if (mem_gnt) begin
        rd_cnt = 0;
        rv_cnt = rv_delay;
      end
    end else begin
      rd_cnt  = 0;
      mem_gnt = mem_req && wr_gnt_en;
    end
    if (mem_req && mem_we) we_cycles++;
  end

  // Transaction-level reference: a queue of accepted-but-unissued stores, the
  // age/progress of the outstanding load, and the last load value delivered.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  int          rd_age = 0;
  bit          rd_granted = 1'b0;
  bit          rd_ready = 1'b0;
  logic [31:0] exp_rddata = '0;

  always @(negedge clk) begin
    int   pend;
    logic exp_req;
    logic exp_stall;
    wr_t  e;
    if (!rst) begin
      wq.delete();
      rd_age     = 0;
      rd_granted = 1'b0;
      rd_ready   = 1'b0;
      exp_rddata = '0;
    end else begin
      pend    = wq.size();
      exp_req = (pend != 0) || (dbus_read && rd_age >= 1 && !rd_granted);
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (mem_req && exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(pend != 0));
        if (pend != 0) begin
          e = wq[0];
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_be", 32'(mem_be), 32'(e.be));
          chk("wr_data", mem_wdata, e.data);
        end else begin
          chk("rd_addr", mem_addr, {dbus_address[31:2], 2'b00});
          chk("rd_be", 32'(mem_be), 32'(dbus_byteenable));
        end
      end
      if (dbus_read)       exp_stall = !rd_ready;
      else if (dbus_write) exp_stall = (pend == WB_DEPTH);
      else                 exp_stall = 1'b0;
      chk("dbus_stall", 32'(dbus_stall), 32'(exp_stall));
      chk("dbus_rddata", dbus_rddata, exp_rddata);

      if (mem_rvalid && rd_granted && !rd_ready) begin
        exp_rddata = mem_rdata;
        rd_ready   = 1'b1;
      end
      if (mem_req && !mem_we && mem_gnt) rd_granted = 1'b1;
      if (dbus_write && !dbus_read && !dbus_stall) begin
        e.addr = {dbus_address[31:2], 2'b00};
        e.be   = dbus_byteenable;
        e.data = dbus_wrdata;
        wq.push_back(e);
      end
      if (mem_req && mem_we && mem_gnt && pend != 0) void'(wq.pop_front());
      if (dbus_read) begin
        if (dbus_stall) rd_age++;
        else begin
          rd_age     = 0;
          rd_granted = 1'b0;
          rd_ready   = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int stalls);
    bit done;
    done            = 1'b0;
    stalls          = 0;
    dbus_read       = 1'b0;
    dbus_write      = 1'b1;
    dbus_address    = a;
    dbus_byteenable = be;
    dbus_wrdata     = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!dbus_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    chk("store_completes", 32'(done), 32'd1);
    step();
    dbus_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] be, input int release_at,
                         output int stalls, output logic [31:0] data);
    bit done;
    done            = 1'b0;
    stalls          = 0;
    data            = '0;
    dbus_write      = 1'b0;
    dbus_read       = 1'b1;
    dbus_address    = a;
    dbus_byteenable = be;
    for (int i = 0; i < 60; i++) begin
      if (i == release_at) wr_gnt_en = 1'b1;
      @(negedge clk);
      if (!dbus_stall) begin
        done = 1'b1;
        data = dbus_rddata;
        break;
      end
      stalls++;
      step();
    end
    chk("load_completes", 32'(done), 32'd1);
    step();
    dbus_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    int          tot;
    int          we0;
    logic [31:0] d;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_stall", 32'(dbus_stall), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_rddata", dbus_rddata, 32'd0);
    step();

    // Single posted store, granted immediately.
    wr_gnt_en = 1'b1;
    do_store(32'h1FD0_0003, 4'b1000, 32'hAB00_0000, s);
    chk("store_no_stall", 32'(s), 32'd0);
    @(negedge clk);
    chk("store_mem_req", 32'(mem_req), 32'd1);
    chk("store_mem_we", 32'(mem_we), 32'd1);
    chk("store_mem_addr", mem_addr, 32'h1FD0_0000);
    chk("store_mem_be", 32'(mem_be), 32'h8);
    chk("store_mem_wdata", mem_wdata, 32'hAB00_0000);
    step();
    step();

    // Fill the buffer with the downstream port blocked.
    wr_gnt_en = 1'b0;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h1FD0_0010 + 32'(i * 4), 4'hF, 32'h1111_0000 + 32'(i), s);
      tot += s;
    end
    chk("four_stores_no_stall", 32'(tot), 32'd0);
    dbus_write      = 1'b1;
    dbus_address    = 32'h1FD0_0020;
    dbus_byteenable = 4'h3;
    dbus_wrdata     = 32'h5555_0005;
    @(negedge clk);
    chk("fifth_stall_full", 32'(dbus_stall), 32'd1);
    step();
    wr_gnt_en = 1'b1;
    @(negedge clk);
    chk("fifth_stall_gnt_cycle", 32'(dbus_stall), 32'd1);
    step();
    wr_gnt_en = 1'b0;
    @(negedge clk);
    chk("fifth_completes", 32'(dbus_stall), 32'd0);
    step();
    dbus_address    = 32'h1FD0_0024;
    dbus_byteenable = 4'hC;
    dbus_wrdata     = 32'h6666_0006;
    @(negedge clk);
    chk("count_stays_full", 32'(dbus_stall), 32'd1);
    step();
    wr_gnt_en = 1'b1;
    do_store(32'h1FD0_0024, 4'hC, 32'h6666_0006, s);
    repeat (6) step();

    // Load behind two buffered stores: drain first, then read.
    wr_gnt_en = 1'b0;
    do_store(32'h1FD0_0030, 4'hF, 32'hA0A0_0001, s);
    do_store(32'h1FD0_0034, 4'hF, 32'hA0A0_0002, s);
    gnt_delay    = 1;
    rv_delay     = 1;
    rd_data_next = 32'h1234_5678;
    do_load(32'h1FD0_1000, 4'hF, 2, s, d);
    chk("drain_load_data", d, 32'h1234_5678);
    chk("drain_load_stall_cycles", 32'(s), 32'd6);

    // Load with empty buffer, grant and data each two cycles late.
    gnt_delay    = 2;
    rv_delay     = 2;
    rd_data_next = 32'hCAFE_F00D;
    we0          = we_cycles;
    do_load(32'h1FD0_2006, 4'h3, -1, s, d);
    chk("slow_load_data", d, 32'hCAFE_F00D);
    chk("slow_load_stall_cycles", 32'(s), 32'd5);
    chk("slow_load_no_writes", 32'(we_cycles - we0), 32'd0);

    // Stray response while idle must not touch the load data.
    step();
    stray_req++;
    step();
    step();
    @(negedge clk);
    chk("stray_rvalid_ignored", dbus_rddata, 32'hCAFE_F00D);
    step();

    // Reset mid-drain: mem_req drops without a clock edge, buffer discarded.
    wr_gnt_en = 1'b0;
    do_store(32'h1FD0_0040, 4'hF, 32'hBBBB_0001, s);
    do_store(32'h1FD0_0044, 4'hF, 32'hBBBB_0002, s);
    #2;
    chk("req_before_reset", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("req_async_clear", 32'(mem_req), 32'd0);
    chk("stall_async_clear", 32'(dbus_stall), 32'd0);
    step();
    step();
    rst       = 1'b1;
    wr_gnt_en = 1'b1;
    @(negedge clk);
    chk("no_write_after_reset", 32'(mem_req), 32'd0);
    step();

    // Reset mid-read: the late response arrives in IDLE and is dropped.
    gnt_delay       = 1;
    rv_delay        = 4;
    rd_data_next    = 32'hFEED_FACE;
    dbus_read       = 1'b1;
    dbus_address    = 32'h1FD0_3000;
    dbus_byteenable = 4'hF;
    step();
    step();
    step();
    dbus_read = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rddata_async_clear", dbus_rddata, 32'd0);
    chk("req_async_clear_read", 32'(mem_req), 32'd0);
    step();
    rst = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("stale_rvalid_ignored", dbus_rddata, 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
